// File: rtl/morse_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : morse_pkg                                                    |
// | Description : Character codes and FSM state constants shared by the      |
// |               Morse text buffer and its lookup table.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package morse_pkg;

    // Character code space: 0 blank, 1-26 letters, 27-36 digits, 63 invalid
    localparam int c_blank       = 0;
    localparam int c_err         = 63;
    localparam int c_letter_base = 1;
    localparam int c_digit_base  = 27;

    // Buffer controller states
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_collect = 2'd1;
    localparam logic [1:0] c_st_lookup  = 2'd2;
    localparam logic [1:0] c_st_write   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/morse_lut.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : morse_lut                                                    |
// | Description : Combinational Morse decoder. Symbols arrive LSB-first       |
// |               (bit 0 = first symbol, dot = 0, dash = 1); the result is a  |
// |               character code, or the invalid code when nothing matches.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module morse_lut
    import morse_pkg::*;
#(
    parameter int MAX_SYM = 5,
    parameter int CHAR_W  = 6,
    parameter int LEN_W   = $clog2(MAX_SYM + 1)
) (
    input  logic [LEN_W-1:0]   i_len,
    input  logic [MAX_SYM-1:0] i_pattern,
    output logic [CHAR_W-1:0]  o_code
);

    logic [7:0] w_key;
    int         w_val;

    // Reorder symbols so the first one is the key MSB; table reads like Morse
    always_comb begin
        w_key = '0;
        for (int i = 0; i < MAX_SYM; i++) begin
            if (i < int'(i_len)) begin
                w_key = {w_key[6:0], i_pattern[i]};
            end
        end
    end

    // Morse table keyed by length and symbol string (0 = dot, 1 = dash)
    always_comb begin
        w_val = c_err;
        case (int'(i_len))
            1: case (w_key)
                8'b0:    w_val = c_letter_base + 4;   // E .
                8'b1:    w_val = c_letter_base + 19;  // T -
                default: w_val = c_err;
            endcase
            2: case (w_key)
                8'b00:   w_val = c_letter_base + 8;   // I ..
                8'b01:   w_val = c_letter_base + 0;   // A .-
                8'b10:   w_val = c_letter_base + 13;  // N -.
                8'b11:   w_val = c_letter_base + 12;  // M --
                default: w_val = c_err;
            endcase
            3: case (w_key)
                8'b000:  w_val = c_letter_base + 18;  // S ...
                8'b001:  w_val = c_letter_base + 20;  // U ..-
                8'b010:  w_val = c_letter_base + 17;  // R .-.
                8'b011:  w_val = c_letter_base + 22;  // W .--
                8'b100:  w_val = c_letter_base + 3;   // D -..
                8'b101:  w_val = c_letter_base + 10;  // K -.-
                8'b110:  w_val = c_letter_base + 6;   // G --.
                8'b111:  w_val = c_letter_base + 14;  // O ---
                default: w_val = c_err;
            endcase
            4: case (w_key)
                8'b0000: w_val = c_letter_base + 7;   // H ....
                8'b0001: w_val = c_letter_base + 21;  // V ...-
                8'b0010: w_val = c_letter_base + 5;   // F ..-.
                8'b0100: w_val = c_letter_base + 11;  // L .-..
                8'b0110: w_val = c_letter_base + 15;  // P .--.
                8'b0111: w_val = c_letter_base + 9;   // J .---
                8'b1000: w_val = c_letter_base + 1;   // B -...
                8'b1001: w_val = c_letter_base + 23;  // X -..-
                8'b1010: w_val = c_letter_base + 2;   // C -.-.
                8'b1011: w_val = c_letter_base + 24;  // Y -.--
                8'b1100: w_val = c_letter_base + 25;  // Z --..
                8'b1101: w_val = c_letter_base + 16;  // Q --.-
                default: w_val = c_err;
            endcase
            5: case (w_key)
                8'b11111: w_val = c_digit_base + 0;   // 0 -----
                8'b01111: w_val = c_digit_base + 1;   // 1 .----
                8'b00111: w_val = c_digit_base + 2;   // 2 ..---
                8'b00011: w_val = c_digit_base + 3;   // 3 ...--
                8'b00001: w_val = c_digit_base + 4;   // 4 ....-
                8'b00000: w_val = c_digit_base + 5;   // 5 .....
                8'b10000: w_val = c_digit_base + 6;   // 6 -....
                8'b11000: w_val = c_digit_base + 7;   // 7 --...
                8'b11100: w_val = c_digit_base + 8;   // 8 ---..
                8'b11110: w_val = c_digit_base + 9;   // 9 ----.
                default:  w_val = c_err;
            endcase
            default: w_val = c_err;
        endcase
    end

    assign o_code = CHAR_W'(w_val);

endmodule
`default_nettype wire

// File: rtl/morse_text_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : morse_text_buffer                                            |
// | Description : Collects dot/dash strobes into a character, decodes it and  |
// |               appends it to a DEPTH-slot display buffer (page or scroll   |
// |               on overflow). Supports space, backspace and clear.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module morse_text_buffer
    import morse_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int MAX_SYM = 5,
    parameter int SCROLL  = 0,
    parameter int CHAR_W  = 6
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           dot,
    input  logic                           dash,
    input  logic                           commit,
    input  logic                           space,
    input  logic                           backspace,
    input  logic                           clear,
    output logic [DEPTH*CHAR_W-1:0]        char_flat,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [$clog2(MAX_SYM+1)-1:0]   pend_len,
    output logic                           busy,
    output logic                           full,
    output logic                           err
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_len_w = $clog2(MAX_SYM + 1);

    logic [1:0]          r_state;
    logic [c_len_w-1:0]  r_pend_len;
    logic [MAX_SYM-1:0]  r_pat;
    logic                r_ovf;
    logic [c_len_w-1:0]  r_lut_len;
    logic [MAX_SYM-1:0]  r_lut_pat;
    logic                r_lut_blank;
    logic                r_lut_ovf;
    logic [CHAR_W-1:0]   r_code;
    logic [CHAR_W-1:0]   r_slot [DEPTH];
    logic [c_cnt_w-1:0]  r_count;
    logic                r_err;

    logic                w_busy;
    logic                w_do_clear;
    logic                w_do_bs;
    logic                w_do_commit;
    logic                w_do_space;
    logic                w_do_sym;
    logic                w_start_char;
    logic                w_start_blank;
    logic                w_erase;
    logic                w_write;
    logic [CHAR_W-1:0]   w_lut_code;

    // Strobe arbitration: nothing is accepted while a character is in flight
    always_comb begin
        w_busy        = (r_state == c_st_lookup) || (r_state == c_st_write);
        w_do_clear    = !w_busy && clear;
        w_do_bs       = !w_busy && !clear && backspace;
        w_do_commit   = !w_busy && !clear && !backspace && commit;
        w_do_space    = !w_busy && !clear && !backspace && !commit && space;
        w_do_sym      = !w_busy && !clear && !backspace && !commit && !space && (dash || dot);
        w_start_char  = w_do_commit && (r_pend_len != '0);
        w_start_blank = w_do_space && (r_pend_len == '0);
        w_erase       = w_do_bs && (r_pend_len == '0) && (r_count != '0);
        w_write       = (r_state == c_st_write);
    end

    // Controller state, pending symbol history and sticky overflow flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_st_idle;
            r_pend_len <= '0;
            r_pat      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                c_st_lookup: r_state <= c_st_write;
                c_st_write:  r_state <= c_st_idle;
                default: begin
                    if (w_do_clear || w_do_bs || w_do_commit) begin
                        r_pend_len <= '0;
                        r_pat      <= '0;
                        r_ovf      <= 1'b0;
                        r_state    <= w_start_char ? c_st_lookup : c_st_idle;
                    end else if (w_start_blank) begin
                        r_state <= c_st_lookup;
                    end else if (w_do_sym) begin
                        if (r_pend_len < c_len_w'(MAX_SYM)) begin
                            for (int i = 0; i < MAX_SYM; i++) begin
                                if (i == int'(r_pend_len)) begin
                                    r_pat[i] <= dash;
                                end
                            end
                            r_pend_len <= r_pend_len + c_len_w'(1);
                            r_state    <= c_st_collect;
                        end else begin
                            r_ovf <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    morse_lut #(
        .MAX_SYM (MAX_SYM),
        .CHAR_W  (CHAR_W),
        .LEN_W   (c_len_w)
    ) u_lut (
        .i_len     (r_lut_len),
        .i_pattern (r_lut_pat),
        .o_code    (w_lut_code)
    );

    // Capture the finished pattern, then register the decoded code in LOOKUP
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lut_len   <= '0;
            r_lut_pat   <= '0;
            r_lut_blank <= 1'b0;
            r_lut_ovf   <= 1'b0;
            r_code      <= '0;
        end else begin
            if (w_start_char || w_start_blank) begin
                r_lut_len   <= r_pend_len;
                r_lut_pat   <= r_pat;
                r_lut_blank <= w_start_blank;
                r_lut_ovf   <= r_ovf;
            end
            if (r_state == c_st_lookup) begin
                if (r_lut_blank) begin
                    r_code <= CHAR_W'(c_blank);
                end else if (r_lut_ovf) begin
                    r_code <= CHAR_W'(c_err);
                end else begin
                    r_code <= w_lut_code;
                end
            end
        end
    end

    // Display slots, occupancy count and the invalid-character pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_slot[k] <= '0;
            end
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_do_clear) begin
                for (int k = 0; k < DEPTH; k++) begin
                    r_slot[k] <= '0;
                end
                r_count <= '0;
            end else if (w_erase) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (k == int'(r_count) - 1) begin
                        r_slot[k] <= '0;
                    end
                end
                r_count <= r_count - c_cnt_w'(1);
            end else if (w_write) begin
                r_err <= (r_code == CHAR_W'(c_err));
                if (r_count != c_cnt_w'(DEPTH)) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        if (k == int'(r_count)) begin
                            r_slot[k] <= r_code;
                        end
                    end
                    r_count <= r_count + c_cnt_w'(1);
                end else if (SCROLL != 0) begin
                    for (int k = 0; k < DEPTH - 1; k++) begin
                        r_slot[k] <= r_slot[k+1];
                    end
                    r_slot[DEPTH-1] <= r_code;
                end else begin
                    for (int k = 1; k < DEPTH; k++) begin
                        r_slot[k] <= '0;
                    end
                    r_slot[0] <= r_code;
                    r_count   <= c_cnt_w'(1);
                end
            end
        end
    end

    // Flatten slots onto the output bus, slot 0 in the low bits
    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_flat
            assign char_flat[g*CHAR_W +: CHAR_W] = r_slot[g];
        end
    endgenerate

    assign count    = r_count;
    assign pend_len = r_pend_len;
    assign busy     = w_busy;
    assign full     = (r_count == c_cnt_w'(DEPTH));
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_morse_text_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_morse_text_buffer                                         |
// | Description : Self-checking bench: a page-mode (DEPTH 8) and a scroll-mode |
// |               (DEPTH 4) buffer share stimulus and are compared each cycle  |
// |               against a string-table reference model.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_morse_text_buffer;

    localparam int MAX_SYM = 5;
    localparam int CHAR_W  = 6;
    localparam int DEPTH_A = 8;
    localparam int DEPTH_B = 4;

    // strobe vector layout: {clear, backspace, commit, space, dash, dot}
    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_DT   = 6'b000001;
    localparam logic [5:0] S_DA   = 6'b000010;
    localparam logic [5:0] S_SP   = 6'b000100;
    localparam logic [5:0] S_CM   = 6'b001000;
    localparam logic [5:0] S_BS   = 6'b010000;
    localparam logic [5:0] S_CLR  = 6'b100000;

    logic clock;
    logic reset_n;
    logic dot, dash, commit, space, backspace, clear;

    logic [DEPTH_A*CHAR_W-1:0] flat_a;
    logic [3:0]                count_a;
    logic [2:0]                pend_a;
    logic                      busy_a, full_a, err_a;
    logic [DEPTH_B*CHAR_W-1:0] flat_b;
    logic [2:0]                count_b;
    logic [2:0]                pend_b;
    logic                      busy_b, full_b, err_b;

    morse_text_buffer #(.DEPTH(DEPTH_A), .MAX_SYM(MAX_SYM), .SCROLL(0), .CHAR_W(CHAR_W)) u_page (
        .clock(clock), .reset_n(reset_n), .dot(dot), .dash(dash), .commit(commit),
        .space(space), .backspace(backspace), .clear(clear), .char_flat(flat_a),
        .count(count_a), .pend_len(pend_a), .busy(busy_a), .full(full_a), .err(err_a)
    );

    morse_text_buffer #(.DEPTH(DEPTH_B), .MAX_SYM(MAX_SYM), .SCROLL(1), .CHAR_W(CHAR_W)) u_scroll (
        .clock(clock), .reset_n(reset_n), .dot(dot), .dash(dash), .commit(commit),
        .space(space), .backspace(backspace), .clear(clear), .char_flat(flat_b),
        .count(count_b), .pend_len(pend_b), .busy(busy_b), .full(full_b), .err(err_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Morse strings indexed by character code (1-26 A-Z, 27-36 digits 0-9)
    string tbl [37] = '{"",
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."};

    // Reference model state, one set per instance (0 = page, 1 = scroll)
    int m_buf  [2][16];
    int m_cnt  [2];
    int m_plen [2];
    bit m_pat  [2][8];
    bit m_ovf  [2];
    int m_busy [2];
    int m_code [2];
    bit m_err  [2];

    function automatic int m_depth(int i);
        return (i == 0) ? DEPTH_A : DEPTH_B;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 16; k++) m_buf[i][k] = 0;
            m_cnt[i] = 0; m_plen[i] = 0; m_ovf[i] = 0;
            m_busy[i] = 0; m_code[i] = 0; m_err[i] = 0;
        end
    endfunction

    function automatic int m_decode(int i);
        string s = "";
        for (int j = 0; j < m_plen[i]; j++) begin
            if (m_pat[i][j]) s = {s, "-"};
            else             s = {s, "."};
        end
        for (int c = 1; c <= 36; c++) begin
            if (tbl[c] == s) return c;
        end
        return 63;
    endfunction

    function automatic void m_write(int i);
        int d = m_depth(i);
        if (m_cnt[i] < d) begin
            m_buf[i][m_cnt[i]] = m_code[i];
            m_cnt[i]++;
        end else if (i == 1) begin
            for (int k = 0; k < d - 1; k++) m_buf[i][k] = m_buf[i][k+1];
            m_buf[i][d-1] = m_code[i];
        end else begin
            for (int k = 0; k < d; k++) m_buf[i][k] = 0;
            m_buf[i][0] = m_code[i];
            m_cnt[i] = 1;
        end
        m_err[i] = (m_code[i] == 63);
    endfunction

    // One clock edge of model behaviour for the strobes sampled at that edge
    function automatic void m_step(int i, logic [5:0] s);
        m_err[i] = 0;
        if (m_busy[i] == 2) begin
            m_busy[i] = 1;
        end else if (m_busy[i] == 1) begin
            m_write(i);
            m_busy[i] = 0;
        end else if (s[5]) begin
            for (int k = 0; k < 16; k++) m_buf[i][k] = 0;
            m_cnt[i] = 0; m_plen[i] = 0; m_ovf[i] = 0;
        end else if (s[4]) begin
            if (m_plen[i] > 0) begin
                m_plen[i] = 0;
            end else if (m_cnt[i] > 0) begin
                m_cnt[i]--;
                m_buf[i][m_cnt[i]] = 0;
            end
            m_ovf[i] = 0;
        end else if (s[3]) begin
            if (m_plen[i] > 0) begin
                m_code[i] = m_ovf[i] ? 63 : m_decode(i);
                m_busy[i] = 2;
                m_plen[i] = 0;
            end
            m_ovf[i] = 0;
        end else if (s[2]) begin
            if (m_plen[i] == 0) begin
                m_code[i] = 0;
                m_busy[i] = 2;
            end
        end else if (s[1] || s[0]) begin
            if (m_plen[i] < MAX_SYM) begin
                m_pat[i][m_plen[i]] = s[1];
                m_plen[i]++;
            end else begin
                m_ovf[i] = 1;
            end
        end
    endfunction

    function automatic logic [63:0] m_flat(int i);
        logic [63:0] r = '0;
        for (int k = 0; k < m_depth(i); k++) r[k*CHAR_W +: CHAR_W] = CHAR_W'(m_buf[i][k]);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_all();
        chk("page.flat",  64'(flat_a),  m_flat(0));
        chk("page.count", 64'(count_a), 64'(m_cnt[0]));
        chk("page.pend",  64'(pend_a),  64'(m_plen[0]));
        chk("page.busy",  64'(busy_a),  64'(m_busy[0] > 0));
        chk("page.full",  64'(full_a),  64'(m_cnt[0] == DEPTH_A));
        chk("page.err",   64'(err_a),   64'(m_err[0]));
        chk("scrl.flat",  64'(flat_b),  m_flat(1));
        chk("scrl.count", 64'(count_b), 64'(m_cnt[1]));
        chk("scrl.pend",  64'(pend_b),  64'(m_plen[1]));
        chk("scrl.busy",  64'(busy_b),  64'(m_busy[1] > 0));
        chk("scrl.full",  64'(full_b),  64'(m_cnt[1] == DEPTH_B));
        chk("scrl.err",   64'(err_b),   64'(m_err[1]));
    endtask

    // Called at a falling edge: drive strobes for one rising edge, then check
    task automatic cyc(input logic [5:0] s);
        {clear, backspace, commit, space, dash, dot} = s;
        @(posedge clock);
        m_step(0, s);
        m_step(1, s);
        @(negedge clock);
        {clear, backspace, commit, space, dash, dot} = S_NONE;
        check_all();
    endtask

    // Key a whole character and let the write complete
    task automatic enter(input string p);
        for (int j = 0; j < p.len(); j++) begin
            if (p[j] == "-") cyc(S_DA);
            else             cyc(S_DT);
        end
        cyc(S_CM);
        cyc(S_NONE);
        cyc(S_NONE);
    endtask

    typedef struct {
        logic [5:0] stb;
        int         cnt;
        int         slot0;
        int         busy;
        int         err;
        int         plen;
    } vec_t;

    vec_t vecs [21];

    initial begin
        vecs[0]  = '{S_CLR,       0, 0, 0, 0, 0};
        vecs[1]  = '{S_DT,        0, 0, 0, 0, 1};
        vecs[2]  = '{S_DA,        0, 0, 0, 0, 2};
        vecs[3]  = '{S_CM,        0, 0, 1, 0, 0};
        vecs[4]  = '{S_DT,        0, 0, 1, 0, 0};
        vecs[5]  = '{S_NONE,      1, 1, 0, 0, 0};
        vecs[6]  = '{S_DT,        1, 1, 0, 0, 1};
        vecs[7]  = '{S_DT,        1, 1, 0, 0, 2};
        vecs[8]  = '{S_DA,        1, 1, 0, 0, 3};
        vecs[9]  = '{S_DA,        1, 1, 0, 0, 4};
        vecs[10] = '{S_CM,        1, 1, 1, 0, 0};
        vecs[11] = '{S_NONE,      1, 1, 1, 0, 0};
        vecs[12] = '{S_NONE,      2, 1, 0, 1, 0};
        vecs[13] = '{S_NONE,      2, 1, 0, 0, 0};
        vecs[14] = '{S_BS | S_CM, 1, 1, 0, 0, 0};
        vecs[15] = '{S_DT,        1, 1, 0, 0, 1};
        vecs[16] = '{S_BS | S_CM, 1, 1, 0, 0, 0};
        vecs[17] = '{S_NONE,      1, 1, 0, 0, 0};
        vecs[18] = '{S_SP,        1, 1, 1, 0, 0};
        vecs[19] = '{S_NONE,      1, 1, 1, 0, 0};
        vecs[20] = '{S_NONE,      2, 1, 0, 0, 0};

        reset_n = 1'b0;
        {clear, backspace, commit, space, dash, dot} = S_NONE;
        m_reset();
        @(negedge clock);
        @(negedge clock);
        check_all();
        reset_n = 1'b1;

        // Directed vectors on the page instance
        for (int v = 0; v < 21; v++) begin
            cyc(vecs[v].stb);
            chk($sformatf("vec%0d.count", v), 64'(count_a), 64'(vecs[v].cnt));
            chk($sformatf("vec%0d.slot0", v), 64'(flat_a[5:0]), 64'(vecs[v].slot0));
            chk($sformatf("vec%0d.busy", v),  64'(busy_a), 64'(vecs[v].busy));
            chk($sformatf("vec%0d.err", v),   64'(err_a), 64'(vecs[v].err));
            chk($sformatf("vec%0d.pend", v),  64'(pend_a), 64'(vecs[v].plen));
        end

        // Page wrap: eight E fill the page, H starts a fresh one
        cyc(S_CLR);
        repeat (8) enter(".");
        chk("wrap.full8", 64'(full_a), 64'd1);
        enter("....");
        chk("wrap.slot0", 64'(flat_a[5:0]), 64'd8);
        chk("wrap.rest",  64'(flat_a[47:6]), 64'd0);
        chk("wrap.count", 64'(count_a), 64'd1);
        chk("wrap.full",  64'(full_a), 64'd0);

        // Scroll: E T A N I leaves T A N I
        cyc(S_CLR);
        enter("."); enter("-"); enter(".-"); enter("-."); enter("..");
        chk("scroll.flat",  64'(flat_b), 64'({6'd9, 6'd14, 6'd1, 6'd20}));
        chk("scroll.count", 64'(count_b), 64'd4);
        chk("scroll.full",  64'(full_b), 64'd1);

        // Unmatched pattern and symbol overflow both produce code 63
        cyc(S_CLR);
        cyc(S_DT); cyc(S_DT); cyc(S_DA); cyc(S_DA);
        cyc(S_CM); cyc(S_NONE); cyc(S_NONE);
        chk("inval.slot0", 64'(flat_a[5:0]), 64'd63);
        chk("inval.err1",  64'(err_a), 64'd1);
        cyc(S_NONE);
        chk("inval.err0",  64'(err_a), 64'd0);
        repeat (6) cyc(S_DT);
        chk("ovf.pend", 64'(pend_a), 64'd5);
        cyc(S_CM); cyc(S_NONE); cyc(S_NONE);
        chk("ovf.slot1", 64'(flat_a[11:6]), 64'd63);
        chk("ovf.err",   64'(err_a), 64'd1);

        // Backspace: first drops pending symbols, second erases a slot
        cyc(S_CLR);
        enter("-"); enter("--");
        cyc(S_DA); cyc(S_DA); cyc(S_BS);
        chk("bs1.pend",  64'(pend_a), 64'd0);
        chk("bs1.count", 64'(count_a), 64'd2);
        chk("bs1.slot1", 64'(flat_a[11:6]), 64'd13);
        cyc(S_BS);
        chk("bs2.count", 64'(count_a), 64'd1);
        chk("bs2.slot1", 64'(flat_a[11:6]), 64'd0);
        chk("bs2.slot0", 64'(flat_a[5:0]), 64'd20);
        cyc(S_CLR | S_DT | S_CM);
        chk("clrprio.count", 64'(count_a), 64'd0);
        chk("clrprio.pend",  64'(pend_a), 64'd0);

        // Reset in LOOKUP aborts the character immediately
        enter(".-");
        cyc(S_DT);
        cyc(S_CM);
        chk("rst.busy_pre", 64'(busy_a), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        m_reset();
        check_all();
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) begin
            cyc(S_NONE);
            chk("rst.count", 64'(count_a), 64'd0);
        end

        // Random strobes, including same-cycle combinations and busy drops
        repeat (3000) begin
            logic [5:0] s;
            s = S_NONE;
            if ($urandom_range(99) < 20) s |= S_DT;
            if ($urandom_range(99) < 20) s |= S_DA;
            if ($urandom_range(99) < 6)  s |= S_SP;
            if ($urandom_range(99) < 15) s |= S_CM;
            if ($urandom_range(99) < 5)  s |= S_BS;
            if ($urandom_range(99) < 1)  s |= S_CLR;
            cyc(s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/morse_text_buffer.md
MORSE_TEXT_BUFFER -- requirements
Module: morse_text_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of character slots, one per display digit.
REQ-002 Parameter MAX_SYM, default 5, maximum dots and dashes per character, so digits 0-9 are supported.
REQ-003 Parameter SCROLL, default 0, overflow mode: 0 = page (clear and restart), 1 = scroll (shift out oldest).
REQ-004 Parameter CHAR_W, default 6, width of a character code.
REQ-005 clock  in  1  single system clock; all logic on its rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 dot, dash  in  1 each  single-cycle strobes adding one symbol (dot = 0, dash = 1).
REQ-008 commit  in  1  single-cycle strobe ending the current character.
REQ-009 space, backspace, clear  in  1 each  single-cycle strobes: write blank, delete, wipe buffer.
REQ-010 char_flat  out  DEPTH*CHAR_W  slot k at [k*CHAR_W +: CHAR_W]; slot 0 is the leftmost digit.
REQ-011 count  out  $clog2(DEPTH+1)  number of occupied slots.
REQ-012 pend_len  out  $clog2(MAX_SYM+1)  number of symbols accumulated for the current character.
REQ-013 busy, full, err  out  1 each  lookup in progress; count==DEPTH; one-cycle pulse on invalid character.

Function
REQ-014 Codes: 0 = blank; 1-26 = A-Z; 27-36 = digits 0-9; 63 = invalid '?'.
REQ-015 FSM states:
- IDLE: pend_len==0.
- COLLECT: pend_len>0.
- LOOKUP: one cycle, pattern registered into the lookup.
- WRITE: one cycle, buffer updated.
REQ-016 A dot or dash in IDLE/COLLECT stores the symbol at bit index pend_len, increments pend_len and enters COLLECT.
REQ-017 Symbols beyond MAX_SYM are dropped and set a sticky overflow flag, which is cleared by commit, backspace, clear or reset.
REQ-018 Commit with pend_len>0 goes LOOKUP then WRITE; buffer, count, full and err update on edge N+2 for a commit sampled at edge N.
REQ-019 Commit with pend_len==0 is a no-op.
REQ-020 Space in IDLE writes code 0 as a character with the same 2-cycle latency; space in COLLECT is ignored.
REQ-021 err pulses for exactly one cycle, in WRITE, when the written code is 63.
REQ-022 Code 63 is written for an unmatched pattern or when the overflow flag is set.
REQ-023 busy is high in LOOKUP and WRITE; all strobes sampled while busy is high are dropped.
REQ-024 Same-cycle priority: clear > backspace > commit > space > dash > dot; lower-priority strobes that cycle are dropped.
REQ-025 Write with count<DEPTH: slot[count] gets the code and count increments.
REQ-026 Write with count==DEPTH, SCROLL=0: all slots go to 0, slot 0 gets the code, count=1.
REQ-027 Write with count==DEPTH, SCROLL=1: slot[k] gets slot[k+1] for every k, slot[DEPTH-1] gets the code, count stays DEPTH.
REQ-028 Backspace with pend_len>0 discards the pending symbols (pend_len=0, state IDLE) and leaves the buffer unchanged.
REQ-029 Backspace with pend_len==0 and count>0 sets slot[count-1]=0 and decrements count; with count==0 it is a no-op.
REQ-030 Clear zeroes all slots, count, pend_len and overflow, and returns the FSM to IDLE in the next cycle.

Reset
REQ-031 Assertion of reset_n low immediately forces:
- state IDLE;
- all slots, count and pend_len to 0;
- the overflow flag, busy, full and err to 0.
REQ-032 Reset asserted during LOOKUP or WRITE aborts the character; no partial write is visible after deassertion.

Structure
REQ-033 Package morse_pkg holds the code constants (BLANK=0, ERR=63, letter/digit bases) and the FSM state enumeration.
REQ-034 Sub-module morse_lut is purely combinational and maps (length, pattern) to CHAR_W bits, returning 63 on no match.
REQ-035 Buffer storage is a flat register array with no RAM inference, so DEPTH up to 16 stays in registers.

Verification
REQ-036 Decode: dot, dash, commit, with DEPTH=8 -> two cycles after commit, slot0=1 (A), count=1, err=0.
REQ-037 Page wrap: eight E entries (dot, commit), then H (4 dots, commit) -> slot0=8, slots1-7=0, count=1, full=0.
REQ-038 Scroll: DEPTH=4, SCROLL=1; enter E, T, A, N, then I -> slots = 20, 1, 14, 9; count=4; full=1.
REQ-039 Invalid input:
- dot, dot, dash, dash, commit -> code 63 written and err high for exactly one cycle;
- six dots then commit -> overflow, 63 written.
REQ-040 Backspace:
- dash, dash, backspace -> pend_len=0 and buffer unchanged;
- a second backspace -> last slot=0, count decremented.
REQ-041 Reset and priority:
- backspace and commit in the same cycle -> only backspace acts;
- reset_n low during LOOKUP -> all outputs 0 and no write appears.
